// File: rtl/wm_cycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wm_cycle_sequencer_pkg
// Purpose  : Phase encoding shared by the wash-cycle sequencer and the Timer,
//            plus small phase-classification helpers.
// Revision : 1.0  initial release
// ============================================================================
package wm_cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_HEAT  = 3'd2,
    PH_WASH  = 3'd3,
    PH_DRAIN = 3'd4,
    PH_SPIN  = 3'd5,
    PH_DONE  = 3'd6,
    PH_FAULT = 3'd7
  } phase_e;

  localparam int unsigned RINSE_CNT_W = 3;

  // FILL..SPIN: a cycle is in progress, door locked, watchdog armed.
  function automatic logic is_running(input phase_e p);
    return (p >= PH_FILL) && (p <= PH_SPIN);
  endfunction

  // DRAIN keeps pumping with the door open; only the other running phases pause.
  function automatic logic is_pausable(input phase_e p);
    return is_running(p) && (p != PH_DRAIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wm_phase_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : wm_phase_watchdog
// Purpose  : Saturating per-phase cycle counter; flags a phase that has run
//            WD_CYCLES enabled cycles. WD_CYCLES = 0 disables it.
// Revision : 1.0  initial release
// ============================================================================
module wm_phase_watchdog #(
  parameter int unsigned WD_CYCLES = 1000,
  parameter int unsigned WD_W      = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WD_W-1:0] C_LAST = WD_W'(WD_CYCLES - 1);
  localparam logic [WD_W-1:0] C_MAX  = '1;

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current enabled cycle is the WD_CYCLES-th one, so the trip lands on this edge.
  assign expired = (WD_CYCLES != 0) && enable && (cnt_q >= C_LAST);

endmodule
`default_nettype wire

// File: rtl/wm_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wm_cycle_sequencer
// Purpose  : Wash-cycle FSM: drives the phase code to the Timer, actuator
//            enables, rinse passes, door pause, abort and watchdog fault.
// Revision : 1.0  initial release
// ============================================================================
module wm_cycle_sequencer
  import wm_cycle_sequencer_pkg::*;
#(
  parameter int unsigned RINSES    = 2,
  parameter int unsigned WD_CYCLES = 1000,
  parameter int unsigned WD_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       door_closed,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Completed,
  output logic [2:0] state,
  output logic       water_valve,
  output logic       heater,
  output logic       motor,
  output logic       motor_fast,
  output logic       drain_pump,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam logic [RINSE_CNT_W-1:0] C_RINSES = RINSE_CNT_W'(RINSES);

  phase_e                 state_q, state_d;
  logic [RINSE_CNT_W-1:0] rinse_q, rinse_d;
  logic                   main_q, main_d;
  logic                   aborted_q, aborted_d;

  logic valve_q, valve_d;
  logic heater_q, heater_d;
  logic motor_q, motor_d;
  logic fast_q, fast_d;
  logic pump_q, pump_d;
  logic lock_q, lock_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fault_q, fault_d;

  logic w_running;
  logic w_pause;
  logic w_full;
  logic w_temp;
  logic w_compl;
  logic w_wd_expired;
  logic w_hold_next;

  assign w_running = is_running(state_q);
  assign w_pause   = is_pausable(state_q) && !door_closed;
  assign w_full    = sig_Full        && !w_pause;
  assign w_temp    = sig_Temperature && !w_pause;
  assign w_compl   = sig_Completed   && !w_pause;

  wm_phase_watchdog #(
    .WD_CYCLES (WD_CYCLES),
    .WD_W      (WD_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (w_running && !w_pause),
    .expired (w_wd_expired)
  );

  // Next-state: phase flags first, then abort and watchdog override in priority order.
  always_comb begin
    state_d   = state_q;
    rinse_d   = rinse_q;
    main_d    = main_q;
    aborted_d = aborted_q;

    case (state_q)
      PH_IDLE: begin
        if (start && door_closed) begin
          state_d   = PH_FILL;
          rinse_d   = '0;
          main_d    = 1'b1;
          aborted_d = 1'b0;
        end
      end
      PH_FILL: begin
        if (w_full) begin
          state_d = main_q ? PH_HEAT : PH_WASH;
        end
      end
      PH_HEAT: begin
        if (w_temp) begin
          state_d = PH_WASH;
        end
      end
      PH_WASH: begin
        if (w_compl) begin
          state_d = PH_DRAIN;
        end
      end
      PH_DRAIN: begin
        if (w_compl) begin
          if (aborted_q) begin
            state_d = PH_IDLE;
          end else if (rinse_q < C_RINSES) begin
            state_d = PH_FILL;
            main_d  = 1'b0;
            rinse_d = rinse_q + 1'b1;
          end else begin
            state_d = PH_SPIN;
          end
        end
      end
      PH_SPIN: begin
        if (w_compl) begin
          state_d = PH_DONE;
        end
      end
      PH_DONE: begin
        if (start || !door_closed) begin
          state_d = PH_IDLE;
        end
      end
      PH_FAULT: begin
        state_d = PH_FAULT;
      end
      default: begin
        state_d = PH_IDLE;
      end
    endcase

    if (w_running && abort) begin
      state_d   = PH_DRAIN;
      rinse_d   = C_RINSES;
      aborted_d = 1'b1;
    end

    if (w_wd_expired) begin
      state_d = PH_FAULT;
    end
  end

  // Outputs are registered from the phase being entered, so they line up with `state`.
  assign w_hold_next = is_pausable(state_d) && !door_closed;

  always_comb begin
    valve_d  = (state_d == PH_FILL) && !w_hold_next;
    heater_d = (state_d == PH_HEAT) && !w_hold_next;
    motor_d  = ((state_d == PH_WASH) || (state_d == PH_SPIN)) && !w_hold_next;
    fast_d   = (state_d == PH_SPIN) && !w_hold_next;
    pump_d   = (state_d == PH_DRAIN) || (state_d == PH_SPIN) || (state_d == PH_FAULT);
    lock_d   = is_running(state_d);
    busy_d   = is_running(state_d);
    done_d   = (state_d == PH_DONE);
    fault_d  = (state_d == PH_FAULT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= PH_IDLE;
      rinse_q   <= '0;
      main_q    <= 1'b0;
      aborted_q <= 1'b0;
      valve_q   <= 1'b0;
      heater_q  <= 1'b0;
      motor_q   <= 1'b0;
      fast_q    <= 1'b0;
      pump_q    <= 1'b0;
      lock_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rinse_q   <= rinse_d;
      main_q    <= main_d;
      aborted_q <= aborted_d;
      valve_q   <= valve_d;
      heater_q  <= heater_d;
      motor_q   <= motor_d;
      fast_q    <= fast_d;
      pump_q    <= pump_d;
      lock_q    <= lock_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign state       = state_q;
  assign water_valve = valve_q;
  assign heater      = heater_q;
  assign motor       = motor_q;
  assign motor_fast  = fast_q;
  assign drain_pump  = pump_q;
  assign door_lock   = lock_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_wm_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_cycle_sequencer
// Purpose  : Scoreboard bench for wm_cycle_sequencer (RINSES=1, WD_CYCLES=50).
// Revision : 1.0  initial release
// ============================================================================
module tb_wm_cycle_sequencer;

  localparam int FULL = 0;
  localparam int TEMP = 1;
  localparam int COMP = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       door_closed = 1'b1;
  logic       sig_Full = 1'b0;
  logic       sig_Temperature = 1'b0;
  logic       sig_Completed = 1'b0;
  logic [2:0] state;
  logic       water_valve, heater, motor, motor_fast, drain_pump, door_lock, busy, done, fault;

  logic [11:0] snap;
  logic [11:0] last_snap = 12'd0;
  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  wm_cycle_sequencer #(
    .RINSES    (1),
    .WD_CYCLES (50),
    .WD_W      (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .door_closed     (door_closed),
    .sig_Full        (sig_Full),
    .sig_Temperature (sig_Temperature),
    .sig_Completed   (sig_Completed),
    .state           (state),
    .water_valve     (water_valve),
    .heater          (heater),
    .motor           (motor),
    .motor_fast      (motor_fast),
    .drain_pump      (drain_pump),
    .door_lock       (door_lock),
    .busy            (busy),
    .done            (done),
    .fault           (fault)
  );

  always #5 clock = ~clock;

  assign snap = {state, water_valve, heater, motor, motor_fast, drain_pump,
                 door_lock, busy, done, fault};

  // Expected {state, valve, heater, motor, fast, pump, lock, busy, done, fault}.
  function automatic logic [11:0] exp_snap(input logic [2:0] st, input logic paused);
    logic v, h, m, mf, p, l, b, d, f;
    v  = (st == 3'd1) && !paused;
    h  = (st == 3'd2) && !paused;
    m  = ((st == 3'd3) || (st == 3'd5)) && !paused;
    mf = (st == 3'd5) && !paused;
    p  = (st == 3'd4) || (st == 3'd5) || (st == 3'd7);
    l  = (st >= 3'd1) && (st <= 3'd5);
    b  = l;
    d  = (st == 3'd6);
    f  = (st == 3'd7);
    return {st, v, h, m, mf, p, l, b, d, f};
  endfunction

  task automatic expect_ev(input logic [2:0] st, input logic paused);
    exp_q.push_back(exp_snap(st, paused));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      FULL:    sig_Full = 1'b1;
      TEMP:    sig_Temperature = 1'b1;
      default: sig_Completed = 1'b1;
    endcase
    tick(1);
    sig_Full = 1'b0;
    sig_Temperature = 1'b0;
    sig_Completed = 1'b0;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every change of state or outputs is a DUT event matched against the queue.
  always @(negedge clock) begin
    if (snap !== last_snap) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got state=%0d outs=%b, required no change (state=%0d outs=%b)",
                 snap[11:9], snap[8:0], last_snap[11:9], last_snap[8:0]);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (snap !== e) begin
          n_fail++;
          $display("FAIL event: got state=%0d outs=%b, required state=%0d outs=%b",
                   snap[11:9], snap[8:0], e[11:9], e[8:0]);
        end
      end
      last_snap = snap;
    end
  end

  initial begin
    tick(2);
    check("reset_state", snap, 12'd0);
    reset = 1'b0;
    tick(2);

    // Normal run with one rinse pass; stray out-of-phase flag first.
    expect_ev(3'd1, 1'b0); start = 1'b1; tick(1); start = 1'b0;
    tick(2); pulse(COMP);
    tick(2); expect_ev(3'd2, 1'b0); pulse(FULL);
    tick(2); expect_ev(3'd3, 1'b0); pulse(TEMP);
    tick(2); expect_ev(3'd4, 1'b0); pulse(COMP);
    tick(2); expect_ev(3'd1, 1'b0); pulse(COMP);
    tick(2); expect_ev(3'd3, 1'b0); pulse(FULL);
    tick(2); expect_ev(3'd4, 1'b0); pulse(COMP);
    tick(2); expect_ev(3'd5, 1'b0); pulse(COMP);
    tick(2); expect_ev(3'd6, 1'b0); pulse(COMP);
    tick(2);
    check("done_flag", {11'd0, done}, 12'd1);
    expect_ev(3'd0, 1'b0); start = 1'b1; tick(1); start = 1'b0;
    tick(2);

    // Start with the door open is ignored.
    door_closed = 1'b0; start = 1'b1; tick(1); start = 1'b0; door_closed = 1'b1;
    tick(2);
    check("start_door_open", {9'd0, state}, 12'd0);

    // Door pause in WASH: motor off, flag ignored, watchdog frozen.
    expect_ev(3'd1, 1'b0); start = 1'b1; tick(1); start = 1'b0;
    tick(1); expect_ev(3'd2, 1'b0); pulse(FULL);
    tick(1); expect_ev(3'd3, 1'b0); pulse(TEMP);
    tick(10);
    expect_ev(3'd3, 1'b1); door_closed = 1'b0; tick(1);
    check("pause_motor_off", {11'd0, motor}, 12'd0);
    tick(5); pulse(COMP); tick(13);
    check("pause_state_hold", {9'd0, state}, 12'd3);
    expect_ev(3'd3, 1'b0); door_closed = 1'b1; tick(1);
    check("resume_motor_on", {11'd0, motor}, 12'd1);
    tick(25);
    expect_ev(3'd4, 1'b0); pulse(COMP);
    door_closed = 1'b0; tick(3); door_closed = 1'b1;
    check("drain_not_paused", {11'd0, drain_pump}, 12'd1);
    tick(1); expect_ev(3'd1, 1'b0); pulse(COMP);
    tick(1); expect_ev(3'd3, 1'b0); pulse(FULL);
    tick(1); expect_ev(3'd4, 1'b0); pulse(COMP);
    tick(1); expect_ev(3'd5, 1'b0); pulse(COMP);
    tick(1); expect_ev(3'd6, 1'b0); pulse(COMP);
    tick(2);
    expect_ev(3'd0, 1'b0); door_closed = 1'b0; tick(1); door_closed = 1'b1;
    tick(2);

    // Abort beats sig_Full in FILL; aborted drain returns to IDLE.
    expect_ev(3'd1, 1'b0); start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    expect_ev(3'd4, 1'b0); abort = 1'b1; sig_Full = 1'b1; tick(1); abort = 1'b0; sig_Full = 1'b0;
    check("abort_to_drain", {9'd0, state}, 12'd4);
    tick(2); expect_ev(3'd0, 1'b0); pulse(COMP);
    tick(3);
    check("abort_no_done", {9'd0, state, done}, 12'd0);

    // Start mid-WASH ignored; then asynchronous reset mid-cycle.
    expect_ev(3'd1, 1'b0); start = 1'b1; tick(1); start = 1'b0;
    tick(1); expect_ev(3'd2, 1'b0); pulse(FULL);
    tick(1); expect_ev(3'd3, 1'b0); pulse(TEMP);
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    check("start_in_wash", {9'd0, state}, 12'd3);
    expect_ev(3'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("async_reset", snap, 12'd0);
    tick(1); reset = 1'b0;
    tick(2);

    // Watchdog: all flags low in HEAT trips FAULT after exactly 50 cycles.
    expect_ev(3'd1, 1'b0); start = 1'b1; tick(1); start = 1'b0;
    tick(2); expect_ev(3'd2, 1'b0); pulse(FULL);
    tick(49);
    check("wd_heat_49", {9'd0, state}, 12'd2);
    expect_ev(3'd7, 1'b0);
    tick(1);
    check("wd_fault_50", {9'd0, state}, 12'd7);
    check("wd_fault_outs", {10'd0, fault, drain_pump}, 12'd3);
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    check("fault_sticky", {9'd0, state}, 12'd7);
    expect_ev(3'd0, 1'b0); reset = 1'b1; tick(1); reset = 1'b0;
    tick(3);

    check("queue_drained", 12'(exp_q.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
